// File: rtl/ex_mem_pipe_stage_if.sv
// Upstream/downstream handshake bundle for ex_mem_pipe_stage.
// The stage uses the slave modport; the driving side (upstream, downstream, flush) uses master.
interface ex_mem_pipe_stage_if #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 3,
  parameter int CTRL_W = 6,
  parameter int RD_W   = 5
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [CTRL_W-1:0]        in_ctrl;
  logic [RD_W-1:0]          in_rd;
  logic                     out_valid;
  logic                     out_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [CTRL_W-1:0]        out_ctrl;
  logic [RD_W-1:0]          out_rd;
  logic [1:0]               out_count;

  modport slave (
    input  flush, in_valid, in_data, in_ctrl, in_rd, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, out_rd, out_count
  );

  modport master (
    output flush, in_valid, in_data, in_ctrl, in_rd, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, out_rd, out_count
  );
endinterface

// File: rtl/ex_mem_pipe_stage.sv
// Pipeline-stage register with valid/ready handshake, flush and bubble control zeroing.
// Define PIPE_SKID_EN to build the two-entry skid buffer with a registered in_ready.
module ex_mem_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 3,
  parameter int CTRL_W = 6,
  parameter int RD_W   = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  ex_mem_pipe_stage_if.slave  bus
);
  localparam int DW = NUM_CH * DATA_W;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
`ifdef PIPE_SKID_EN
  localparam logic [1:0] FULL  = 2'd2;
`endif

  logic [1:0]        state, state_nxt;
  logic [DW-1:0]     m_data;
  logic [CTRL_W-1:0] m_ctrl;
  logic [RD_W-1:0]   m_rd;
  logic              out_valid, in_ready;
  logic              in_fire, out_fire;
  logic              ld_m;

`ifdef PIPE_SKID_EN
  logic [DW-1:0]     s_data;
  logic [CTRL_W-1:0] s_ctrl;
  logic [RD_W-1:0]   s_rd;
  logic              ld_s, ld_m_from_s;
  logic              in_ready_q;

  assign in_ready = in_ready_q;
`else
  assign in_ready = !out_valid || bus.out_ready;
`endif

  assign out_valid = (state != EMPTY);
  assign in_fire   = bus.in_valid && in_ready;
  assign out_fire  = out_valid && bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = m_data;
  assign bus.out_ctrl  = m_ctrl;
  assign bus.out_rd    = m_rd;
  // State encoding doubles as the occupancy count.
  assign bus.out_count = state;

  always_comb begin
    state_nxt = state;
    ld_m      = 1'b0;
`ifdef PIPE_SKID_EN
    ld_s        = 1'b0;
    ld_m_from_s = 1'b0;
`endif
    case (state)
      EMPTY: begin
        if (in_fire) begin
          ld_m      = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          ld_m = 1'b1;
`ifdef PIPE_SKID_EN
        end else if (in_fire) begin
          ld_s      = 1'b1;
          state_nxt = FULL;
`endif
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
`ifdef PIPE_SKID_EN
      FULL: begin
        if (out_fire) begin
          ld_m_from_s = 1'b1;
          state_nxt   = ONE;
        end
      end
`endif
      default: state_nxt = EMPTY;
    endcase
    // Flush wins: a same-cycle in_fire handshakes but its payload is dropped.
    if (bus.flush) begin
      state_nxt = EMPTY;
      ld_m      = 1'b0;
`ifdef PIPE_SKID_EN
      ld_s        = 1'b0;
      ld_m_from_s = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      m_data <= '0;
      m_ctrl <= '0;
      m_rd   <= '0;
    end else begin
      state <= state_nxt;
      if (ld_m) begin
        m_data <= bus.in_data;
        m_ctrl <= bus.in_ctrl;
        m_rd   <= bus.in_rd;
`ifdef PIPE_SKID_EN
      end else if (ld_m_from_s) begin
        m_data <= s_data;
        m_ctrl <= s_ctrl;
        m_rd   <= s_rd;
`endif
      end else if (state_nxt == EMPTY) begin
        // Bubble: kill control so no write can fire, payload keeps its last value.
        m_ctrl <= '0;
      end
    end
  end

`ifdef PIPE_SKID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_data     <= '0;
      s_ctrl     <= '0;
      s_rd       <= '0;
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= (state_nxt != FULL);
      if (ld_s) begin
        s_data <= bus.in_data;
        s_ctrl <= bus.in_ctrl;
        s_rd   <= bus.in_rd;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Self-checking bench for ex_mem_pipe_stage: queue-based occupancy model plus directed literals.
// Honours PIPE_SKID_EN the same way as the design.
module tb_ex_mem_pipe_stage;
  localparam int DATA_W = 32;
  localparam int NUM_CH = 3;
  localparam int CTRL_W = 6;
  localparam int RD_W   = 5;
  localparam int DW     = NUM_CH * DATA_W;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [DW-1:0]     d;
    logic [CTRL_W-1:0] c;
    logic [RD_W-1:0]   r;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_mem_pipe_stage_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CTRL_W(CTRL_W), .RD_W(RD_W)) bus ();

  ex_mem_pipe_stage #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CTRL_W(CTRL_W), .RD_W(RD_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  ent_t q[$];
  ent_t shown;
  bit   m_rdy;
  bit   held;
  int   seq;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
    end
  endtask

  function automatic bit model_rdy();
    if (CAP == 2) return m_rdy;
    return (q.size() == 0) || (bus.out_ready == 1'b1);
  endfunction

  task automatic model_reset();
    q.delete();
    shown = '0;
    m_rdy = 1'b1;
    held  = 1'b0;
  endtask

  // Queue view: head is what the outputs show, flush empties it, a drain keeps the last head's payload.
  task automatic model_edge();
    bit ir, inf, outf;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ir   = model_rdy();
    inf  = bus.in_valid && ir;
    outf = (q.size() != 0) && bus.out_ready;
    if (outf) void'(q.pop_front());
    if (inf && !bus.flush) q.push_back(ent_t'{bus.in_data, bus.in_ctrl, bus.in_rd});
    if (bus.flush) q.delete();
    if (q.size() != 0) shown = q[0];
    m_rdy = (q.size() < 2);
    held  = bus.in_valid && !inf;
  endtask

  task automatic compare();
    bit v;
    v = (q.size() != 0);
    chk("out_valid", 128'(bus.out_valid), 128'(v));
    chk("out_count", 128'(bus.out_count), 128'(q.size()));
    chk("out_ctrl",  128'(bus.out_ctrl),  v ? 128'(q[0].c) : 128'(0));
    chk("out_data",  128'(bus.out_data),  128'(shown.d));
    chk("out_rd",    128'(bus.out_rd),    128'(shown.r));
    chk("in_ready",  128'(bus.in_ready),  128'(model_rdy()));
`ifndef PIPE_SKID_EN
    chk("count_le1", 128'(bus.out_count <= 2'd1), 128'(1));
`endif
  endtask

  task automatic pre();
    #1 compare();
  endtask

  task automatic post();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic tick();
    pre();
    post();
  endtask

  task automatic set_in(input bit v, input logic [31:0] ch0);
    bus.in_valid = v;
    bus.in_data  = {$urandom, $urandom, ch0};
    bus.in_ctrl  = CTRL_W'($urandom);
    bus.in_rd    = RD_W'($urandom);
  endtask

  // Present the next sequence number unless a stalled payload must be held.
  task automatic next_seq();
    if (!held) begin
      seq++;
      set_in(1'b1, 32'(seq));
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    bus.flush     = 1'b0;
    repeat (4) begin
      if (!held) bus.in_valid = 1'b0;
      tick();
    end
  endtask

  initial begin
    int fires;
    int exp_seq;
    model_reset();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    set_in(1'b0, 32'h0);
    seq = 0;

    // Reset values
    @(negedge clk);
    pre();
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_in_ready",  128'(bus.in_ready),  128'(1));
    chk("rst_out_count", 128'(bus.out_count), 128'(0));
    chk("rst_out_data",  128'(bus.out_data),  128'(0));
    post();

    // First transfer after reset: one-cycle latency
    rst_n = 1'b1;
    set_in(1'b1, 32'h0000_00AA);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    pre();
    chk("first_ch0",   128'(bus.out_data[31:0]), 128'(32'hAA));
    chk("first_valid", 128'(bus.out_valid),      128'(1));
    post();
    drain();

    // Streaming: 8 back-to-back entries at full rate
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) set_in(1'b1, 32'(100 + i));
      else bus.in_valid = 1'b0;
      pre();
      chk("stream_in_ready", 128'(bus.in_ready), 128'(1));
      if (i > 0) chk("stream_out", {95'(0), bus.out_valid, bus.out_data[31:0]}, {95'(0), 1'b1, 32'(100 + i - 1)});
      post();
    end
    drain();

    // Stall for three cycles mid-stream, then drain in order
    seq = 0;
    held = 1'b0;
    fires = 0;
    exp_seq = 1;
    bus.out_ready = 1'b0;
    next_seq();
    pre();
    chk("stall_in_ready0", 128'(bus.in_ready), 128'(1));
    post();
    next_seq();
    pre();
    chk("stall_count1", 128'(bus.out_count), 128'(1));
`ifdef PIPE_SKID_EN
    chk("stall_in_ready1", 128'(bus.in_ready), 128'(1));
`else
    chk("stall_in_ready1", 128'(bus.in_ready), 128'(0));
`endif
    post();
    next_seq();
    pre();
    chk("stall_count2", 128'(bus.out_count), 128'(CAP));
    chk("stall_in_ready2", 128'(bus.in_ready), 128'(0));
    post();
    bus.out_ready = 1'b1;
    repeat (6) begin
      if (!held) bus.in_valid = 1'b0;
      pre();
      if (bus.out_valid && bus.out_ready) begin
        chk("drain_order", 128'(bus.out_data[31:0]), 128'(exp_seq));
        exp_seq++;
        fires++;
      end
      post();
    end
    chk("drain_fires", 128'(fires), 128'(CAP + 1));
    drain();

    // Flush with a same-cycle in_fire and out_fire: nothing survives
    bus.out_ready = 1'b0;
    set_in(1'b1, 32'hF00D_0001);
    tick();
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    set_in(1'b1, 32'hF00D_0002);
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) begin
      pre();
      chk("flush_gone", {bus.out_valid, bus.out_count, bus.out_ctrl}, '0);
      post();
    end

`ifdef PIPE_SKID_EN
    // Flush while FULL
    bus.out_ready = 1'b0;
    set_in(1'b1, 32'hBEEF_0001);
    tick();
    set_in(1'b1, 32'hBEEF_0002);
    tick();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    pre();
    chk("full_count",    128'(bus.out_count), 128'(2));
    chk("full_in_ready", 128'(bus.in_ready),  128'(0));
    post();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) begin
      pre();
      chk("full_flush_gone", {bus.out_valid, bus.out_count, bus.out_ctrl}, '0);
      post();
    end
`else
    // No skid: stall is visible on in_ready in the same cycle
    bus.out_ready = 1'b0;
    set_in(1'b1, 32'hC0DE_0001);
    tick();
    bus.in_valid = 1'b0;
    pre();
    chk("noskid_in_ready", 128'(bus.in_ready), 128'(0));
    post();
`endif
    drain();

    // Bubble safety: control cleared, payload retained
    bus.out_ready = 1'b1;
    set_in(1'b1, 32'h1234_5678);
    bus.in_ctrl = '1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    pre();
    chk("bubble_ctrl",  128'(bus.out_ctrl),       128'(0));
    chk("bubble_data",  128'(bus.out_data[31:0]), 128'(32'h1234_5678));
    chk("bubble_valid", 128'(bus.out_valid),      128'(0));
    post();

    // Randomised traffic with an asynchronous reset mid-stream
    for (int n = 0; n < 3000; n++) begin
      if (!held) set_in($urandom_range(0, 3) != 0, $urandom);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.flush     = ($urandom_range(0, 19) == 0);
      if (n == 1500) begin
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst", {bus.out_valid, bus.out_count, bus.out_ctrl, bus.out_rd, bus.out_data},
            '0);
        chk("async_rst_in_ready", 128'(bus.in_ready), 128'(1));
        model_reset();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
      end else begin
        tick();
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
